// File: rtl/counter_sequencer.sv
// counter_sequencer: run/stop sequenced modulo counter with latched config.
// Ports: clk, rst (sync, active-high); start/stop/tick_en/load control;
//   up/oneshot/limit config latched on start from IDLE; load_value preload;
//   count (registered), busy (RUN|HOLD), tc and done one-cycle pulses.
module counter_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_en,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] lim_q, lim_n;
  logic             up_q, up_n;
  logic             os_q, os_n;
  logic             tc_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
      lim_q <= '1;
      up_q  <= 1'b1;
      os_q  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      tc    <= tc_n;
      done  <= done_n;
      lim_q <= lim_n;
      up_q  <= up_n;
      os_q  <= os_n;
    end
  end

  assign busy = (state == RUN) || (state == HOLD);

  always_comb begin
    state_n = state;
    count_n = count;
    lim_n   = lim_q;
    up_n    = up_q;
    os_n    = os_q;
    tc_n    = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load)
          count_n = load_value;
        if (start) begin
          lim_n   = limit;
          up_n    = up;
          os_n    = oneshot;
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = HOLD;
        end else if (tick_en) begin
          if (up_q) begin
            // Terminal at limit; values above limit wrap naturally, no tc.
            if (count == lim_q) begin
              tc_n = 1'b1;
              if (os_q) begin
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                count_n = '0;
              end
            end else begin
              count_n = count + WIDTH'(1);
            end
          end else begin
            if (count == '0) begin
              tc_n = 1'b1;
              if (os_q) begin
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                count_n = lim_q;
              end
            end else begin
              count_n = count - WIDTH'(1);
            end
          end
        end
      end
      HOLD: begin
        if (stop)
          state_n = IDLE;
        else if (start)
          state_n = RUN;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed vectors for counter_sequencer, WIDTH=3.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_counter_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         tick_en = 1'b0;
  logic         up = 1'b1;
  logic         oneshot = 1'b0;
  logic [W-1:0] limit = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .tick_en    (tick_en),
    .up         (up),
    .oneshot    (oneshot),
    .limit      (limit),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input int b,
                            input int t, input int d);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".tc"}, int'(tc), t);
    check({tag, ".done"}, int'(done), d);
  endtask

  // Two stop pulses: RUN -> HOLD -> IDLE.
  task automatic park();
    start = 0; tick_en = 0; load = 0; stop = 1;
    step();
    step();
    stop = 0;
  endtask

  initial begin
    int exp_c [6];
    int exp_t [6];

    // Reset
    step();
    step();
    expect_out("rst", 0, 0, 0, 0);
    rst = 0;

    // T1: limit 7, up, continuous; tick with start is not counted
    limit = 7; up = 1; oneshot = 0; start = 1; tick_en = 1;
    step();
    expect_out("t1.start", 0, 1, 0, 0);
    start = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      expect_out($sformatf("t1.tick%0d", i), i % 8, 1, (i == 8) ? 1 : 0, 0);
    end
    park();
    expect_out("t1.idle", 1, 0, 0, 0);

    // T2: limit 5, down, oneshot, load 3 with start
    limit = 5; up = 0; oneshot = 1; load = 1; load_value = 3; start = 1;
    step();
    expect_out("t2.start", 3, 1, 0, 0);
    load = 0; start = 0; tick_en = 1;
    step(); expect_out("t2.c2", 2, 1, 0, 0);
    step(); expect_out("t2.c1", 1, 1, 0, 0);
    step(); expect_out("t2.c0", 0, 1, 0, 0);
    step(); expect_out("t2.done", 0, 0, 1, 1);
    start = 1;
    step(); expect_out("t2.start_ignored", 0, 0, 0, 0);
    tick_en = 0;
    step(); expect_out("t2.restart", 0, 1, 0, 0);
    park();
    expect_out("t2.idle", 0, 0, 0, 0);

    // T3: stop beats tick; resume; stop beats start in HOLD
    limit = 7; up = 1; oneshot = 0; load = 1; load_value = 4; start = 1;
    step();
    expect_out("t3.start", 4, 1, 0, 0);
    load = 0; start = 0; stop = 1; tick_en = 1;
    step(); expect_out("t3.hold", 4, 1, 0, 0);
    stop = 0; start = 1;
    step(); expect_out("t3.resume", 4, 1, 0, 0);
    start = 0;
    step(); expect_out("t3.tick", 5, 1, 0, 0);
    tick_en = 0; stop = 1;
    step(); expect_out("t3.hold2", 5, 1, 0, 0);
    start = 1;
    step(); expect_out("t3.abort", 5, 0, 0, 0);
    stop = 0; start = 0; limit = 0;
    step(); expect_out("t3.idle", 5, 0, 0, 0);

    // T4: limit 2, up, continuous, load 6 above limit
    limit = 2; up = 1; oneshot = 0; load = 1; load_value = 6; start = 1;
    step();
    expect_out("t4.start", 6, 1, 0, 0);
    load = 0; start = 0; tick_en = 1;
    exp_c = '{7, 0, 1, 2, 0, 1};
    exp_t = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out($sformatf("t4.tick%0d", i), exp_c[i], 1, exp_t[i], 0);
    end
    park();

    // T5: reset mid-count with tc pending
    limit = 5; up = 1; oneshot = 0; load = 1; load_value = 4; start = 1;
    step();
    load = 0; start = 0; tick_en = 1;
    step(); expect_out("t5.c5", 5, 1, 0, 0);
    rst = 1;
    step(); expect_out("t5.rst1", 0, 0, 0, 0);
    step(); expect_out("t5.rst2", 0, 0, 0, 0);
    rst = 0;
    step(); expect_out("t5.post", 0, 0, 0, 0);
    tick_en = 0;

    // T6: limit 0, up, continuous; limit change while busy ignored
    limit = 0; up = 1; oneshot = 0; start = 1;
    step();
    expect_out("t6.start", 0, 1, 0, 0);
    start = 0; tick_en = 1;
    step(); expect_out("t6.tick0", 0, 1, 1, 0);
    limit = 3;
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out($sformatf("t6.tick%0d", i), 0, 1, 1, 0);
    end
    tick_en = 0;
    step(); expect_out("t6.notick", 0, 1, 0, 0);
    park();
    expect_out("t6.idle", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
